// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter that serialises write and read register commands onto a
// single I2C master command port and routes each completion to its requester.
module i2c_cmd_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        WR_REQ_VALID,
   output logic        WR_REQ_READY,
   input  logic [19:0] WR_REQ_ADDR_DATA,
   input  logic        RD_REQ_VALID,
   output logic        RD_REQ_READY,
   input  logic [11:0] RD_REQ_ADDR,
   output logic        CMD_VALID,
   input  logic        CMD_READY,
   output logic        CMD_RW,
   output logic [3:0]  CMD_DEV,
   output logic [7:0]  CMD_REG,
   output logic [7:0]  CMD_WDATA,
   input  logic        CMD_DONE,
   input  logic        CMD_NACK,
   input  logic [7:0]  CMD_RDATA,
   output logic        WR_RSP_VALID,
   input  logic        WR_RSP_READY,
   output logic [1:0]  WR_RSP,
   output logic        RD_RSP_VALID,
   input  logic        RD_RSP_READY,
   output logic [1:0]  RD_RSP,
   output logic [7:0]  RD_RSP_DATA
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q;
   logic        last_rd_q;
   logic [15:0] cnt_q;
   logic        cmd_valid_q;
   logic        cmd_rw_q;
   logic [3:0]  cmd_dev_q;
   logic [7:0]  cmd_reg_q;
   logic [7:0]  cmd_wdata_q;
   logic        wr_rsp_valid_q;
   logic        rd_rsp_valid_q;
   logic [1:0]  rsp_code_q;
   logic [7:0]  rsp_data_q;

   logic idle;
   logic grant_wr;
   logic grant_rd;
   logic rsp_hs;

   // Ties go to the requester that did not win last time.
   assign idle     = (state_q == S_IDLE) && !ARESET;
   assign grant_wr = idle && WR_REQ_VALID && (!RD_REQ_VALID || last_rd_q);
   assign grant_rd = idle && RD_REQ_VALID && !grant_wr;
   assign rsp_hs   = (wr_rsp_valid_q && WR_RSP_READY) || (rd_rsp_valid_q && RD_RSP_READY);

   assign WR_REQ_READY = grant_wr;
   assign RD_REQ_READY = grant_rd;
   assign CMD_VALID    = cmd_valid_q;
   assign CMD_RW       = cmd_rw_q;
   assign CMD_DEV      = cmd_dev_q;
   assign CMD_REG      = cmd_reg_q;
   assign CMD_WDATA    = cmd_wdata_q;
   assign WR_RSP_VALID = wr_rsp_valid_q;
   assign RD_RSP_VALID = rd_rsp_valid_q;
   assign WR_RSP       = rsp_code_q;
   assign RD_RSP       = rsp_code_q;
   assign RD_RSP_DATA  = rsp_data_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q        <= S_IDLE;
         last_rd_q      <= 1'b1;
         cnt_q          <= '0;
         cmd_valid_q    <= 1'b0;
         cmd_rw_q       <= 1'b0;
         cmd_dev_q      <= '0;
         cmd_reg_q      <= '0;
         cmd_wdata_q    <= '0;
         wr_rsp_valid_q <= 1'b0;
         rd_rsp_valid_q <= 1'b0;
         rsp_code_q     <= '0;
         rsp_data_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_wr) begin
                  last_rd_q   <= 1'b0;
                  cmd_rw_q    <= 1'b0;
                  cmd_dev_q   <= WR_REQ_ADDR_DATA[19:16];
                  cmd_reg_q   <= WR_REQ_ADDR_DATA[15:8];
                  cmd_wdata_q <= WR_REQ_ADDR_DATA[7:0];
                  cmd_valid_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end else if (grant_rd) begin
                  last_rd_q   <= 1'b1;
                  cmd_rw_q    <= 1'b1;
                  cmd_dev_q   <= RD_REQ_ADDR[11:8];
                  cmd_reg_q   <= RD_REQ_ADDR[7:0];
                  cmd_wdata_q <= 8'h00;
                  cmd_valid_q <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (CMD_READY) begin
                  cmd_valid_q <= 1'b0;
                  cnt_q       <= '0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A completion in the timeout cycle still counts as a completion.
               if (CMD_DONE) begin
                  rsp_code_q     <= CMD_NACK ? 2'b10 : 2'b00;
                  rsp_data_q     <= cmd_rw_q ? CMD_RDATA : 8'h00;
                  wr_rsp_valid_q <= !cmd_rw_q;
                  rd_rsp_valid_q <= cmd_rw_q;
                  state_q        <= S_RESP;
               end else if (cnt_q == TO_LAST) begin
                  rsp_code_q     <= 2'b11;
                  rsp_data_q     <= 8'h00;
                  wr_rsp_valid_q <= !cmd_rw_q;
                  rd_rsp_valid_q <= cmd_rw_q;
                  state_q        <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_hs) begin
                  wr_rsp_valid_q <= 1'b0;
                  rd_rsp_valid_q <= 1'b0;
                  state_q        <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomised transaction-level bench for i2c_cmd_arbiter: each command's grant,
// forwarded fields, completion code and timing are predicted from the block's rules.
module tb_i2c_cmd_arbiter;

   localparam int T = 8;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        WR_REQ_VALID, WR_REQ_READY;
   logic [19:0] WR_REQ_ADDR_DATA;
   logic        RD_REQ_VALID, RD_REQ_READY;
   logic [11:0] RD_REQ_ADDR;
   logic        CMD_VALID, CMD_READY, CMD_RW;
   logic [3:0]  CMD_DEV;
   logic [7:0]  CMD_REG, CMD_WDATA;
   logic        CMD_DONE, CMD_NACK;
   logic [7:0]  CMD_RDATA;
   logic        WR_RSP_VALID, WR_RSP_READY;
   logic [1:0]  WR_RSP;
   logic        RD_RSP_VALID, RD_RSP_READY;
   logic [1:0]  RD_RSP;
   logic [7:0]  RD_RSP_DATA;

   int   n_cmp = 0;
   int   n_err = 0;
   logic last_rd_m;

   i2c_cmd_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .WR_REQ_VALID(WR_REQ_VALID), .WR_REQ_READY(WR_REQ_READY), .WR_REQ_ADDR_DATA(WR_REQ_ADDR_DATA),
      .RD_REQ_VALID(RD_REQ_VALID), .RD_REQ_READY(RD_REQ_READY), .RD_REQ_ADDR(RD_REQ_ADDR),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RW(CMD_RW), .CMD_DEV(CMD_DEV),
      .CMD_REG(CMD_REG), .CMD_WDATA(CMD_WDATA), .CMD_DONE(CMD_DONE), .CMD_NACK(CMD_NACK),
      .CMD_RDATA(CMD_RDATA),
      .WR_RSP_VALID(WR_RSP_VALID), .WR_RSP_READY(WR_RSP_READY), .WR_RSP(WR_RSP),
      .RD_RSP_VALID(RD_RSP_VALID), .RD_RSP_READY(RD_RSP_READY), .RD_RSP(RD_RSP),
      .RD_RSP_DATA(RD_RSP_DATA)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outs();
      chk("rst_wr_ready", 32'(WR_REQ_READY), 0);
      chk("rst_rd_ready", 32'(RD_REQ_READY), 0);
      chk("rst_cmd_valid", 32'(CMD_VALID), 0);
      chk("rst_cmd_rw", 32'(CMD_RW), 0);
      chk("rst_cmd_dev", 32'(CMD_DEV), 0);
      chk("rst_cmd_reg", 32'(CMD_REG), 0);
      chk("rst_cmd_wdata", 32'(CMD_WDATA), 0);
      chk("rst_wr_rsp_valid", 32'(WR_RSP_VALID), 0);
      chk("rst_rd_rsp_valid", 32'(RD_RSP_VALID), 0);
      chk("rst_wr_rsp", 32'(WR_RSP), 0);
      chk("rst_rd_rsp", 32'(RD_RSP), 0);
      chk("rst_rd_rsp_data", 32'(RD_RSP_DATA), 0);
   endtask

   task automatic check_cmd(input logic rd, input logic [19:0] wd, input logic [11:0] ra,
                            input logic v);
      chk("cmd_valid", 32'(CMD_VALID), 32'(v));
      chk("cmd_rw", 32'(CMD_RW), 32'(rd));
      chk("cmd_dev", 32'(CMD_DEV), rd ? 32'(ra[11:8]) : 32'(wd[19:16]));
      chk("cmd_reg", 32'(CMD_REG), rd ? 32'(ra[7:0]) : 32'(wd[15:8]));
      if (!rd) chk("cmd_wdata", 32'(CMD_WDATA), 32'(wd[7:0]));
      chk("busy_wr_ready", 32'(WR_REQ_READY), 0);
      chk("busy_rd_ready", 32'(RD_REQ_READY), 0);
   endtask

   // mode: 0 write only, 1 read only, 2 both requesters valid.
   task automatic run_txn(input int mode, input logic [19:0] wd, input logic [11:0] ra,
                          input int stall, input int dly, input logic nack,
                          input logic [7:0] rdat, input int rstall);
      logic       exp_rd;
      logic [1:0] code;
      logic [7:0] edata;
      int         last;
      exp_rd = (mode == 1) || (mode == 2 && !last_rd_m);
      @(negedge ACLK);
      WR_REQ_VALID = (mode != 1); RD_REQ_VALID = (mode != 0);
      WR_REQ_ADDR_DATA = wd; RD_REQ_ADDR = ra;
      CMD_READY = 1'b0; CMD_DONE = 1'b0; WR_RSP_READY = 1'b0; RD_RSP_READY = 1'b0;
      #1;
      chk("grant_wr_ready", 32'(WR_REQ_READY), 32'(!exp_rd));
      chk("grant_rd_ready", 32'(RD_REQ_READY), 32'(exp_rd));
      chk("idle_cmd_valid", 32'(CMD_VALID), 0);
      @(posedge ACLK);
      last_rd_m = exp_rd;
      for (int k = 0; k <= stall; k++) begin
         @(negedge ACLK);
         CMD_READY = (k == stall);
         CMD_DONE  = ($urandom_range(0, 2) == 0);
         CMD_NACK  = 1'b1;
         CMD_RDATA = 8'($urandom);
         #1;
         check_cmd(exp_rd, wd, ra, 1'b1);
         chk("issue_wr_rsp_valid", 32'(WR_RSP_VALID), 0);
         chk("issue_rd_rsp_valid", 32'(RD_RSP_VALID), 0);
         @(posedge ACLK);
      end
      last = (dly < T) ? dly : T - 1;
      for (int j = 0; j <= last; j++) begin
         @(negedge ACLK);
         CMD_READY = 1'($urandom);
         CMD_DONE  = (j == dly);
         CMD_NACK  = (j == dly) ? nack : 1'($urandom);
         CMD_RDATA = (j == dly) ? rdat : 8'($urandom);
         #1;
         check_cmd(exp_rd, wd, ra, 1'b0);
         chk("wait_wr_rsp_valid", 32'(WR_RSP_VALID), 0);
         chk("wait_rd_rsp_valid", 32'(RD_RSP_VALID), 0);
         @(posedge ACLK);
      end
      code  = (dly < T) ? (nack ? 2'b10 : 2'b00) : 2'b11;
      edata = (dly < T) ? rdat : 8'h00;
      for (int k = 0; k <= rstall; k++) begin
         @(negedge ACLK);
         CMD_DONE = 1'($urandom); CMD_NACK = 1'b1; CMD_RDATA = 8'($urandom);
         WR_RSP_READY = exp_rd ? 1'($urandom) : (k == rstall);
         RD_RSP_READY = exp_rd ? (k == rstall) : 1'($urandom);
         #1;
         chk("resp_wr_valid", 32'(WR_RSP_VALID), 32'(!exp_rd));
         chk("resp_rd_valid", 32'(RD_RSP_VALID), 32'(exp_rd));
         if (exp_rd) begin
            chk("rd_rsp_code", 32'(RD_RSP), 32'(code));
            chk("rd_rsp_data", 32'(RD_RSP_DATA), 32'(edata));
         end else begin
            chk("wr_rsp_code", 32'(WR_RSP), 32'(code));
         end
         chk("resp_cmd_valid", 32'(CMD_VALID), 0);
         chk("resp_wr_ready", 32'(WR_REQ_READY), 0);
         chk("resp_rd_ready", 32'(RD_REQ_READY), 0);
         @(posedge ACLK);
      end
   endtask

   task automatic idle_gap();
      @(negedge ACLK);
      WR_REQ_VALID = 1'b0; RD_REQ_VALID = 1'b0; CMD_DONE = 1'($urandom); CMD_READY = 1'b1;
      #1;
      chk("gap_wr_ready", 32'(WR_REQ_READY), 0);
      chk("gap_rd_ready", 32'(RD_REQ_READY), 0);
      chk("gap_cmd_valid", 32'(CMD_VALID), 0);
      chk("gap_wr_rsp_valid", 32'(WR_RSP_VALID), 0);
      chk("gap_rd_rsp_valid", 32'(RD_RSP_VALID), 0);
      @(posedge ACLK);
   endtask

   task automatic apply_reset();
      @(negedge ACLK);
      ARESET = 1'b1; WR_REQ_VALID = 1'b1; RD_REQ_VALID = 1'b1;
      @(posedge ACLK);
      #1;
      check_reset_outs();
      @(negedge ACLK);
      ARESET = 1'b0; WR_REQ_VALID = 1'b0; RD_REQ_VALID = 1'b0;
      last_rd_m = 1'b1;
   endtask

   initial begin
      ARESET = 1'b1; WR_REQ_VALID = 1'b0; RD_REQ_VALID = 1'b0;
      WR_REQ_ADDR_DATA = '0; RD_REQ_ADDR = '0; CMD_READY = 1'b0;
      CMD_DONE = 1'b0; CMD_NACK = 1'b0; CMD_RDATA = '0;
      WR_RSP_READY = 1'b0; RD_RSP_READY = 1'b0;
      last_rd_m = 1'b1;
      repeat (2) @(posedge ACLK);
      apply_reset();

      run_txn(0, 20'hA355C, 12'h000, 0, 4, 1'b0, 8'h00, 0);
      run_txn(1, 20'h00000, 12'hA10, 0, 2, 1'b1, 8'h77, 0);
      apply_reset();
      for (int i = 0; i < 4; i++)
         run_txn(2, 20'($urandom), 12'($urandom), 0, 1, 1'b0, 8'($urandom), 0);
      run_txn(1, 20'h12345, 12'h5C3, 1, 10, 1'b0, 8'h99, 0);
      run_txn(1, 20'h12345, 12'h5C3, 0, 7, 1'b0, 8'h3C, 0);
      run_txn(0, 20'hF00FF, 12'h000, 0, 9, 1'b1, 8'h00, 1);
      run_txn(2, 20'h7AB12, 12'h4E0, 6, 3, 1'b0, 8'h5A, 4);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle_gap();
         run_txn(int'($urandom_range(0, 2)), 20'($urandom), 12'($urandom),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
                 1'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end

      // Abandon a command while it waits for completion.
      @(negedge ACLK);
      WR_REQ_VALID = 1'b1; RD_REQ_VALID = 1'b0; WR_REQ_ADDR_DATA = 20'h3C0DE;
      CMD_READY = 1'b1; CMD_DONE = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      WR_REQ_VALID = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      CMD_READY = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      ARESET = 1'b1;
      @(posedge ACLK);
      #1;
      check_reset_outs();
      @(negedge ACLK);
      ARESET = 1'b0;
      last_rd_m = 1'b1;
      idle_gap();
      run_txn(2, 20'h61234, 12'h9AB, 0, 0, 1'b0, 8'h11, 0);
      run_txn(2, 20'h61234, 12'h9AB, 0, 0, 1'b0, 8'h22, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
